// File: rtl/spi_seq_pkg.sv
// rtl/spi_seq_pkg.sv - shared FSM encoding and default register map for the SPI APB sequencer
// Contents: 4-bit sequencer state encoding, default SPI core register addresses,
//           default STATUS bit index of the "RX FIFO empty" flag.
package spi_seq_pkg;

   localparam int STATE_W = 4;

   localparam logic [6:0] ADDR_TXDATA_DEF = 7'h0C;
   localparam logic [6:0] ADDR_RXDATA_DEF = 7'h08;
   localparam logic [6:0] ADDR_STATUS_DEF = 7'h20;
   localparam int         RXEMPTY_BIT_DEF = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE        = 4'd0,
      ST_WR_SETUP    = 4'd1,
      ST_WR_ACCESS   = 4'd2,
      ST_GAP1        = 4'd3,
      ST_POLL_SETUP  = 4'd4,
      ST_POLL_ACCESS = 4'd5,
      ST_GAP2        = 4'd6,
      ST_RD_SETUP    = 4'd7,
      ST_RD_ACCESS   = 4'd8,
      ST_RSP         = 4'd9
   } seq_state_e;

endpackage

// File: rtl/spi_apb_sequencer_if.sv
// rtl/spi_apb_sequencer_if.sv - command/response streams plus APB master bus of the sequencer
// Signals: cmd_valid/cmd_ready/cmd_data command stream, rsp_valid/rsp_ready/rsp_data/rsp_err
//          response stream, busy, PADDR/PSEL/PENABLE/PWRITE/PWDATA/PRDATA APB bus.
// Modports: master = sequencer side, slave = acquisition logic + SPI core side.
interface spi_apb_sequencer_if #(
   parameter int APB_DWIDTH = 8,
   parameter int FRAME_SIZE = 8
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic [FRAME_SIZE-1:0] cmd_data;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [FRAME_SIZE-1:0] rsp_data;
   logic                  rsp_err;
   logic                  busy;
   logic [6:0]            PADDR;
   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [APB_DWIDTH-1:0] PWDATA;
   logic [APB_DWIDTH-1:0] PRDATA;

   modport master (
      input  cmd_valid, cmd_data, rsp_ready, PRDATA,
      output cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
             PADDR, PSEL, PENABLE, PWRITE, PWDATA
   );

   modport slave (
      output cmd_valid, cmd_data, rsp_ready, PRDATA,
      input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
             PADDR, PSEL, PENABLE, PWRITE, PWDATA
   );
endinterface

// File: rtl/spi_apb_master_if.sv
// rtl/spi_apb_master_if.sv - two-phase APB driver with req/ack handshake and read-data capture
// Ports: PCLK, PRESETN (async active-low); req_i/write_i/addr_i/wdata_i request held for
//        SETUP+ACCESS; ack_o single-cycle pulse in ACCESS; rdata_o = PRDATA during a read ack,
//        else 0; psel_o/penable_o/pwrite_o/paddr_o/pwdata_o/prdata_i APB bus.
module spi_apb_master_if #(
   parameter int DWIDTH = 8
) (
   input  logic              PCLK,
   input  logic              PRESETN,
   input  logic              req_i,
   input  logic              write_i,
   input  logic [6:0]        addr_i,
   input  logic [DWIDTH-1:0] wdata_i,
   output logic              ack_o,
   output logic [DWIDTH-1:0] rdata_o,
   output logic              psel_o,
   output logic              penable_o,
   output logic              pwrite_o,
   output logic [6:0]        paddr_o,
   output logic [DWIDTH-1:0] pwdata_o,
   input  logic [DWIDTH-1:0] prdata_i
);
   logic access_q, access_d;

   // First cycle of a request is SETUP, second is ACCESS; the requester drops req after ack,
   // which guarantees an idle cycle before the next SETUP.
   assign access_d = req_i & ~access_q;

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) access_q <= 1'b0;
      else          access_q <= access_d;
   end

   assign psel_o    = req_i;
   assign penable_o = req_i & access_q;
   assign ack_o     = req_i & access_q;
   assign pwrite_o  = req_i & write_i;
   assign paddr_o   = req_i ? addr_i : 7'd0;
   assign pwdata_o  = (req_i & write_i) ? wdata_i : '0;
   assign rdata_o   = (ack_o & ~write_i) ? prdata_i : '0;
endmodule

// File: rtl/spi_apb_sequencer.sv
// rtl/spi_apb_sequencer.sv - CPU-less APB master: write TXDATA, poll STATUS, read RXDATA, return word
// Optional macro: SPI_APB_SEQUENCER_TIMEOUT_EN bounds STATUS polling to TIMEOUT_CYCLES reads
//                 and reports a timeout as rsp_err=1 with rsp_data=0.
// Ports: PCLK clock; PRESETN async active-low reset;
//        bus (spi_apb_sequencer_if.master): cmd stream in, rsp stream out, busy, APB master.
module spi_apb_sequencer
   import spi_seq_pkg::*;
#(
   parameter int         APB_DWIDTH     = 8,
   parameter int         FRAME_SIZE     = 8,
   parameter logic [6:0] ADDR_TXDATA    = ADDR_TXDATA_DEF,
   parameter logic [6:0] ADDR_RXDATA    = ADDR_RXDATA_DEF,
   parameter logic [6:0] ADDR_STATUS    = ADDR_STATUS_DEF,
   parameter int         RXEMPTY_BIT    = RXEMPTY_BIT_DEF,
   parameter int         TIMEOUT_CYCLES = 1023
) (
   input logic                 PCLK,
   input logic                 PRESETN,
   spi_apb_sequencer_if.master bus
);
   seq_state_e            state_q, state_d;
   logic [FRAME_SIZE-1:0] cmd_q, cmd_d;
   logic [FRAME_SIZE-1:0] rsp_data_q, rsp_data_d;
   logic                  alive_q;
   logic                  cmd_ready_w, cmd_fire, rx_empty, poll_expired;
   logic                  req, wr, ack;
   logic [6:0]            addr;
   logic [APB_DWIDTH-1:0] wdata, rdata;

   // alive_q keeps cmd_ready low while reset is asserted even though the FSM sits in IDLE.
   assign cmd_ready_w   = alive_q & (state_q == ST_IDLE);
   assign cmd_fire      = bus.cmd_valid & cmd_ready_w;
   assign rx_empty      = rdata[RXEMPTY_BIT];
   assign bus.cmd_ready = cmd_ready_w;
   assign bus.rsp_valid = (state_q == ST_RSP);
   assign bus.rsp_data  = rsp_data_q;
   assign bus.busy      = (state_q != ST_IDLE);

`ifdef SPI_APB_SEQUENCER_TIMEOUT_EN
   logic [15:0] poll_cnt_q, poll_cnt_d;
   logic        rsp_err_q, rsp_err_d;

   // Expired on the poll that would make the empty-poll count reach TIMEOUT_CYCLES.
   assign poll_expired = (poll_cnt_q == 16'(TIMEOUT_CYCLES - 1));

   always_comb begin
      poll_cnt_d = poll_cnt_q;
      rsp_err_d  = rsp_err_q;
      if (cmd_fire) begin
         poll_cnt_d = 16'd0;
         rsp_err_d  = 1'b0;
      end else if (state_q == ST_POLL_ACCESS && ack && rx_empty) begin
         poll_cnt_d = poll_cnt_q + 16'd1;
         if (poll_expired) rsp_err_d = 1'b1;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         poll_cnt_q <= 16'd0;
         rsp_err_q  <= 1'b0;
      end else begin
         poll_cnt_q <= poll_cnt_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

   assign bus.rsp_err = rsp_err_q;
`else
   assign poll_expired = 1'b0;
   assign bus.rsp_err  = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      rsp_data_d = rsp_data_q;
      req        = 1'b0;
      wr         = 1'b0;
      addr       = 7'd0;
      wdata      = '0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_fire) begin
               cmd_d   = bus.cmd_data;
               state_d = ST_WR_SETUP;
            end
         end
         ST_WR_SETUP, ST_WR_ACCESS: begin
            req   = 1'b1;
            wr    = 1'b1;
            addr  = ADDR_TXDATA;
            wdata = APB_DWIDTH'(cmd_q);
            if (state_q == ST_WR_SETUP) state_d = ST_WR_ACCESS;
            else if (ack)               state_d = ST_GAP1;
         end
         ST_GAP1: state_d = ST_POLL_SETUP;
         ST_POLL_SETUP, ST_POLL_ACCESS: begin
            req  = 1'b1;
            addr = ADDR_STATUS;
            if (state_q == ST_POLL_SETUP) state_d = ST_POLL_ACCESS;
            else if (ack) begin
               if (!rx_empty) state_d = ST_GAP2;
               else if (poll_expired) begin
                  rsp_data_d = '0;
                  state_d    = ST_RSP;
               end else state_d = ST_GAP1;
            end
         end
         ST_GAP2: state_d = ST_RD_SETUP;
         ST_RD_SETUP, ST_RD_ACCESS: begin
            req  = 1'b1;
            addr = ADDR_RXDATA;
            if (state_q == ST_RD_SETUP) state_d = ST_RD_ACCESS;
            else if (ack) begin
               rsp_data_d = rdata[FRAME_SIZE-1:0];
               state_d    = ST_RSP;
            end
         end
         ST_RSP: if (bus.rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN) begin
         state_q    <= ST_IDLE;
         cmd_q      <= '0;
         rsp_data_q <= '0;
         alive_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         rsp_data_q <= rsp_data_d;
         alive_q    <= 1'b1;
      end
   end

   spi_apb_master_if #(.DWIDTH(APB_DWIDTH)) u_apb (
      .PCLK      (PCLK),
      .PRESETN   (PRESETN),
      .req_i     (req),
      .write_i   (wr),
      .addr_i    (addr),
      .wdata_i   (wdata),
      .ack_o     (ack),
      .rdata_o   (rdata),
      .psel_o    (bus.PSEL),
      .penable_o (bus.PENABLE),
      .pwrite_o  (bus.PWRITE),
      .paddr_o   (bus.PADDR),
      .pwdata_o  (bus.PWDATA),
      .prdata_i  (bus.PRDATA)
   );
endmodule
